// File: rtl/corr_ctrl_pkg.sv
// Shared definitions for the correlator frame-sync controller:
// FSM state encoding, correlator compare-result codes and a match helper.
package corr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_HUNT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCK   = 3'd4
  } state_e;

  localparam logic [1:0] CMP_NONE  = 2'b00;
  localparam logic [1:0] CMP_EXACT = 2'b01;
  localparam logic [1:0] CMP_ERR1  = 2'b10;
  localparam logic [1:0] CMP_INV   = 2'b11;

  // Exact and 1-bit-error results both count as a preamble match
  function automatic logic is_match(input logic [1:0] res);
    case (res)
      CMP_EXACT, CMP_ERR1: return 1'b1;
      CMP_NONE, CMP_INV:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hdr_serializer.sv
// Header serializer: holds the latched preamble and shifts HDR_REPEAT copies
// out MSB-first over a valid/ready handshake. done_o flags the edge on which
// the final bit is accepted so the controller leaves HEADER on that same edge.
module hdr_serializer #(
  parameter int PRE_W      = 5,
  parameter int HDR_REPEAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load_i,
  input  logic [PRE_W-1:0] preamble_i,
  input  logic             hdr_ready_i,
  output logic             hdr_bit_o,
  output logic             hdr_valid_o,
  output logic             done_o
);

  localparam int BCW = (PRE_W > 1) ? $clog2(PRE_W) : 1;
  localparam int RCW = (HDR_REPEAT > 1) ? $clog2(HDR_REPEAT) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(PRE_W - 1);
  localparam logic [RCW-1:0] LAST_REP = RCW'(HDR_REPEAT - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] sh_q;
  logic [BCW-1:0]   bit_q;
  logic [RCW-1:0]   rep_q;
  logic             valid_q;
  logic             accept;

  assign accept      = valid_q & ena & hdr_ready_i;
  assign done_o      = accept & (bit_q == LAST_BIT) & (rep_q == LAST_REP);
  assign hdr_valid_o = valid_q & ena;
  assign hdr_bit_o   = valid_q & sh_q[PRE_W-1];

  // Latch preamble on load, advance one bit per accepted handshake, reload per copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pre_q   <= preamble_i;
      sh_q    <= preamble_i;
      bit_q   <= '0;
      rep_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      if (bit_q == LAST_BIT) begin
        bit_q <= '0;
        sh_q  <= pre_q;
        if (rep_q == LAST_REP) begin
          rep_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          rep_q <= rep_q + 1'b1;
        end
      end else begin
        bit_q <= bit_q + 1'b1;
        sh_q  <= sh_q << 1;
      end
    end
  end

endmodule

// File: rtl/corr_sync_ctrl.sv
// Frame-sync sequencer: sends the preamble header, then hunts, verifies and
// holds frame lock from the correlator compare stream.
// Optional build macro SYNC_STATS_EN adds saturating lock/loss event counters.
module corr_sync_ctrl
  import corr_ctrl_pkg::*;
#(
  parameter int PRE_W      = 5,
  parameter int HDR_REPEAT = 4,
  parameter int FRAME_LEN  = 16,
  parameter int VERIFY_CNT = 3,
  parameter int MISS_MAX   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [PRE_W-1:0] preamble,
  output logic             hdr_bit,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  input  logic             cmp_valid,
  input  logic [1:0]       cmp_result,
  output logic [2:0]       state_o,
  output logic             locked,
  output logic             frame_strobe,
  output logic             err_1bit,
  output logic             lock_lost
`ifdef SYNC_STATS_EN
  ,
  output logic [7:0]       lock_cnt,
  output logic [7:0]       loss_cnt
`endif
);

  localparam int BW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(VERIFY_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_LEN - 1);
  localparam logic [HW-1:0] HITS_LAST = HW'(VERIFY_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

  state_e        state_q;
  logic [BW-1:0] beat_q;
  logic [HW-1:0] hits_q;
  logic [MW-1:0] miss_q;
  logic          locked_q;
  logic          strobe_q;
  logic          err_q;
  logic          lost_q;
  logic          load;
  logic          hdr_done;
  logic          hit;
  logic          on_time;

  assign load    = ena & start & (state_q == ST_IDLE);
  assign hit     = is_match(cmp_result);
  assign on_time = (beat_q == BEAT_LAST);

  assign state_o      = state_q;
  assign locked       = locked_q;
  assign frame_strobe = strobe_q & ena;
  assign err_1bit     = err_q & ena;
  assign lock_lost    = lost_q & ena;

  hdr_serializer #(
    .PRE_W      (PRE_W),
    .HDR_REPEAT (HDR_REPEAT)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .load_i      (load),
    .preamble_i  (preamble),
    .hdr_ready_i (hdr_ready),
    .hdr_bit_o   (hdr_bit),
    .hdr_valid_o (hdr_valid),
    .done_o      (hdr_done)
  );

  // Sync FSM with beat/hit/miss counters and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
      if (ena) begin
        case (state_q)
          ST_IDLE: begin
            if (start) state_q <= ST_HEADER;
          end
          ST_HEADER: begin
            if (hdr_done) state_q <= ST_HUNT;
          end
          ST_HUNT: begin
            if (cmp_valid && hit) begin
              beat_q <= '0;
              miss_q <= '0;
              if (VERIFY_CNT == 1) begin
                state_q  <= ST_LOCK;
                locked_q <= 1'b1;
                hits_q   <= '0;
              end else begin
                state_q <= ST_VERIFY;
                hits_q  <= HW'(1);
              end
            end
          end
          ST_VERIFY: begin
            if (cmp_valid) begin
              beat_q <= on_time ? '0 : beat_q + 1'b1;
              if (on_time) begin
                if (hit) begin
                  if (hits_q == HITS_LAST) begin
                    state_q  <= ST_LOCK;
                    locked_q <= 1'b1;
                    miss_q   <= '0;
                    hits_q   <= '0;
                  end else begin
                    hits_q <= hits_q + 1'b1;
                  end
                end else begin
                  state_q <= ST_HUNT;
                  hits_q  <= '0;
                end
              end
            end
          end
          ST_LOCK: begin
            if (cmp_valid) begin
              beat_q <= on_time ? '0 : beat_q + 1'b1;
              if (on_time) begin
                if (hit) begin
                  strobe_q <= 1'b1;
                  err_q    <= (cmp_result == CMP_ERR1);
                  miss_q   <= '0;
                end else if (miss_q == MISS_LAST) begin
                  lost_q   <= 1'b1;
                  state_q  <= ST_HUNT;
                  locked_q <= 1'b0;
                  miss_q   <= '0;
                end else begin
                  miss_q <= miss_q + 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SYNC_STATS_EN
  logic [7:0] lock_cnt_q;
  logic [7:0] loss_cnt_q;
  logic       lock_entry;
  logic       lock_drop;

  assign lock_entry = ena & cmp_valid & hit &
                      (((state_q == ST_HUNT) && (VERIFY_CNT == 1)) ||
                       ((state_q == ST_VERIFY) && on_time && (hits_q == HITS_LAST)));
  assign lock_drop  = ena & cmp_valid & ~hit & (state_q == ST_LOCK) & on_time &
                      (miss_q == MISS_LAST);
  assign lock_cnt   = lock_cnt_q;
  assign loss_cnt   = loss_cnt_q;

  // Saturating counts of lock acquisitions and lock losses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      if (lock_entry && (lock_cnt_q != 8'hFF)) lock_cnt_q <= lock_cnt_q + 8'd1;
      if (lock_drop && (loss_cnt_q != 8'hFF)) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end
`endif

endmodule
